// File: rtl/delay_sched.sv
// rtl/delay_sched.sv - Corner-selectable data delay line with flush-and-reload on corner change.
module delay_sched #(
    parameter int MIN_DLY = 3,
    parameter int TYP_DLY = 4,
    parameter int MAX_DLY = 5
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       en,
    input  logic       a,
    input  logic       cfg_req,
    input  logic [1:0] cfg_sel,
    output logic       cfg_ack,
    output logic       busy,
    output logic       y,
    output logic       y_vld,
    output logic [1:0] cur_sel
);

    localparam logic [1:0] S_IDLE  = 2'd0;
    localparam logic [1:0] S_RUN   = 2'd1;
    localparam logic [1:0] S_FLUSH = 2'd2;
    localparam logic [1:0] S_LOAD  = 2'd3;

    localparam logic [4:0] MIN_D = 5'(MIN_DLY);
    localparam logic [4:0] TYP_D = 5'(TYP_DLY);
    localparam logic [4:0] MAX_D = 5'(MAX_DLY);

    logic [1:0]         r_state;
    logic [MAX_DLY-1:0] r_sr;
    logic [MAX_DLY-1:0] r_vsr;
    logic [4:0]         r_dly;
    logic [1:0]         r_cur_sel;
    logic [1:0]         r_pend_sel;
    logic [3:0]         r_cnt;

    logic               w_tap_d;
    logic               w_tap_v;
    logic               w_out_en;
    logic [MAX_DLY-1:0] w_sr_shift;
    logic [MAX_DLY-1:0] w_vsr_shift;

    function automatic logic [4:0] sel_dly(input logic [1:0] sel);
        case (sel)
            2'b00:   sel_dly = MIN_D;
            2'b10:   sel_dly = MAX_D;
            default: sel_dly = TYP_D;
        endcase
    endfunction

    // Output tap at position dly-1; selected by loop to keep index widths exact.
    always_comb begin
        w_tap_d = 1'b0;
        w_tap_v = 1'b0;
        for (int i = 0; i < MAX_DLY; i++) begin
            if (5'(i) == r_dly - 5'd1) begin
                w_tap_d = r_sr[i];
                w_tap_v = r_vsr[i];
            end
        end
    end

    assign w_out_en    = (r_state == S_RUN) || (r_state == S_FLUSH);
    assign w_sr_shift  = (r_sr << 1) | MAX_DLY'(a);
    assign w_vsr_shift = (r_vsr << 1) | MAX_DLY'(1'b1);

    assign y_vld   = w_out_en & w_tap_v;
    assign y       = y_vld & w_tap_d;
    assign busy    = (r_state == S_FLUSH) || (r_state == S_LOAD);
    assign cfg_ack = (r_state == S_LOAD);
    assign cur_sel = r_cur_sel;

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state    <= S_IDLE;
            r_sr       <= '0;
            r_vsr      <= '0;
            r_dly      <= TYP_D;
            r_cur_sel  <= 2'b01;
            r_pend_sel <= 2'b01;
            r_cnt      <= 4'd0;
        end else begin
            case (r_state)
                S_IDLE: begin
                    r_sr  <= '0;
                    r_vsr <= '0;
                    if (cfg_req) begin
                        r_pend_sel <= cfg_sel;
                        r_state    <= S_LOAD;
                    end else if (en) begin
                        r_state <= S_RUN;
                    end
                end
                S_RUN: begin
                    if (!en) begin
                        r_sr    <= '0;
                        r_vsr   <= '0;
                        r_state <= S_IDLE;
                    end else begin
                        r_sr  <= w_sr_shift;
                        r_vsr <= w_vsr_shift;
                        if (cfg_req) begin
                            r_pend_sel <= cfg_sel;
                            r_cnt      <= 4'(r_dly - 5'd1);
                            r_state    <= S_FLUSH;
                        end
                    end
                end
                S_FLUSH: begin
                    // Drain with zeros so every pre-request sample still reaches the old tap.
                    if (!en) begin
                        r_sr    <= '0;
                        r_vsr   <= '0;
                        r_state <= S_LOAD;
                    end else begin
                        r_sr  <= r_sr << 1;
                        r_vsr <= r_vsr << 1;
                        if (r_cnt == 4'd0) begin
                            r_state <= S_LOAD;
                        end else begin
                            r_cnt <= r_cnt - 4'd1;
                        end
                    end
                end
                default: begin
                    r_dly     <= sel_dly(r_pend_sel);
                    r_cur_sel <= (r_pend_sel == 2'b11) ? 2'b01 : r_pend_sel;
                    r_sr      <= '0;
                    r_vsr     <= '0;
                    r_state   <= en ? S_RUN : S_IDLE;
                end
            endcase
        end
    end

endmodule
